pipeline_loader: RTL and testbench
==================================

# pipeline_loader

Sequencer that sits directly upstream of the 5-stage `pipeline` core and drives its preload, run-control and verification ports. It accepts a stream of I-MEM/D-MEM preload words from a host over a valid/ready handshake, then on `go` asserts `start` for a programmed number of cycles. It waits a drain period for write-back to finish, reads back register file and D-MEM locations `0..RB_COUNT-1`, and returns each pair to the host over a second valid/ready stream.

## Interface
- `RUN_CYCLES`, default 6: cycles `start` is held high (1..255).
- `DRAIN_CYCLES`, default 5: idle cycles after `start` falls, before readback (0..255).
- `RB_COUNT`, default 6: number of readback indices (1..8, limited by the 3-bit regfile address).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `cmd_valid`  in  1  host preload word valid.
- `cmd_ready`  out  1  loader accepts a preload word this cycle.
- `cmd_type`  in  1  0 = I-MEM, 1 = D-MEM.
- `cmd_addr`  in  9  target address (D-MEM uses `[7:0]`; bit 8 ignored).
- `cmd_data`  in  64  payload (I-MEM uses `[31:0]`).
- `go`  in  1  single-cycle run request.
- `busy`  out  1  high from go acceptance until the done pulse.
- `done`  out  1  one-cycle pulse after the final readback handshake.
- `imem_waddr_pre`  out  9  to the pipeline.
- `instr_write_pre`  out  32  to the pipeline.
- `instr_we_pre`  out  1  to the pipeline.
- `dmem_waddr_pre`  out  8  to the pipeline.
- `dmem_wdata_pre`  out  64  to the pipeline.
- `dmem_we_pre`  out  1  to the pipeline.
- `start`  out  1  pipeline run enable.
- `regfile_raddr_ver`  out  3  readback register address.
- `mem_raddr_ver`  out  8  readback D-MEM address.
- `regfile_rdata_ver`  in  64  from the pipeline.
- `mem_rdata_ver`  in  64  from the pipeline.
- `rb_valid`  out  1  readback beat valid.
- `rb_ready`  in  1  host accepts the readback beat.
- `rb_index`  out  3  index of the current beat.
- `rb_data`  out  128  `{mem_rdata_ver, regfile_rdata_ver}` captured for `rb_index`.

## Operation
- The FSM has six states: IDLE, RUN, DRAIN, RADDR, RVALID, DONE.
- **IDLE**
  - `cmd_ready = !go`, so `go` has priority and a command presented in the same cycle as `go` is not accepted.
  - When a command is accepted, the matching write enable (`instr_we_pre` or `dmem_we_pre`) is registered high for exactly one cycle, with its address and data registered alongside.
  - Back-to-back accepts issue one write per cycle.
  - `go` moves the FSM to RUN.
- **RUN**: `start = 1`. An 8-bit down-counter is loaded with `RUN_CYCLES`; at terminal count the FSM moves to DRAIN, or straight to RADDR when `DRAIN_CYCLES = 0`.
- **DRAIN**: `start = 0`. The counter is loaded with `DRAIN_CYCLES`; at terminal count the FSM moves to RADDR.
- **RADDR**: `regfile_raddr_ver` and `mem_raddr_ver` hold `idx`, zero-extended, for one full cycle. At the end of that cycle both read-data inputs are captured into `rb_data`, and the FSM moves to RVALID. This tolerates either a combinational read or a one-cycle registered read in the pipeline.
- **RVALID**
  - `rb_valid = 1`; `rb_data` and `rb_index` stay stable until `rb_valid && rb_ready`.
  - On that handshake: if `idx == RB_COUNT-1` go to DONE, otherwise `idx++` and return to RADDR.
- **DONE**: `done = 1` for one cycle, then IDLE; `idx` is cleared.
- `go` is ignored in every state except IDLE, and `cmd_ready = 0` outside IDLE.
- **Reset**
  - All outputs go to 0, including `start`, both write enables, all addresses and `rb_data`. This takes effect asynchronously, including mid-RUN and mid-readback.
  - State returns to IDLE and `idx` and the counter clear.

## Timing
- Preload write latency: a word accepted at edge E drives the pipeline write port during the cycle E→E+1.
- `go` sampled at edge G:
  - `start` is high from G to G+RUN_CYCLES.
  - The first RADDR cycle begins at G+RUN_CYCLES+DRAIN_CYCLES.
  - The first `rb_valid` rises at G+RUN_CYCLES+DRAIN_CYCLES+1, which is 12 cycles with the defaults.
- The last preload accepted at G-1 is written before `start` rises.
- With `rb_ready` tied high, each readback beat costs 2 cycles.
- `done` pulses one cycle after the final handshake; `busy` deasserts on the same edge that `done` asserts.

## Test plan
- Preload 8 I-MEM words (LD R2,R0; LD R3,R0; 3×NOOP; ST R2,R1; 2×NOOP) and D-MEM `{4,2,3,4,0x64,6,7,8}` back-to-back with `cmd_valid` held high → 8 consecutive write cycles, each enable high for exactly 1 cycle, with addresses 0..7 in order.
- `go` with the defaults → `start` high for exactly 6 cycles, first `rb_valid` 12 cycles after G, and beats index 0..5 with D-MEM words `{4,2,3,4,0x64,6}` in the upper 64 bits.
- `rb_ready` low for 5 cycles on beat 2 → `rb_valid`, `rb_index = 2` and `rb_data` held stable; no address change; `done` arrives 5 cycles later than the unstalled run.
- `go` and `cmd_valid` in the same IDLE cycle → `cmd_ready = 0`, no write issued, RUN entered. A second `go` during RUN → ignored, and `start` width is still 6.
- `reset` asserted in the 3rd RUN cycle → `start` and `busy` fall immediately, not at the next edge. After release, `cmd_ready = 1`, and a fresh `go` reproduces the full 6-cycle run.
- `DRAIN_CYCLES = 0`, `RB_COUNT = 1` → RADDR immediately follows the last `start` cycle, there is a single beat with index 0, then `done`.

Source files
------------

// File: rtl/pipeline_loader.sv
// pipeline_loader: host-facing sequencer for the 5-stage pipeline core.
// Streams preload words into I-MEM/D-MEM, runs the core for a fixed number of
// cycles, waits for write-back to drain, then returns {D-MEM, regfile} pairs
// for indices 0..RB_COUNT-1 over a valid/ready readback stream.
module pipeline_loader #(
  parameter int RUN_CYCLES   = 6,
  parameter int DRAIN_CYCLES = 5,
  parameter int RB_COUNT     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_type,
  input  logic [8:0]   cmd_addr,
  input  logic [63:0]  cmd_data,
  input  logic         go,
  output logic         busy,
  output logic         done,
  output logic [8:0]   imem_waddr_pre,
  output logic [31:0]  instr_write_pre,
  output logic         instr_we_pre,
  output logic [7:0]   dmem_waddr_pre,
  output logic [63:0]  dmem_wdata_pre,
  output logic         dmem_we_pre,
  output logic         start,
  output logic [2:0]   regfile_raddr_ver,
  output logic [7:0]   mem_raddr_ver,
  input  logic [63:0]  regfile_rdata_ver,
  input  logic [63:0]  mem_rdata_ver,
  output logic         rb_valid,
  input  logic         rb_ready,
  output logic [2:0]   rb_index,
  output logic [127:0] rb_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_RADDR  = 3'd3,
    S_RVALID = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Counters hold "cycles remaining minus one" so terminal count is zero.
  localparam logic [7:0] RUN_LOAD   = 8'(RUN_CYCLES - 1);
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [2:0] LAST_IDX   = 3'(RB_COUNT - 1);

  state_t         state_reg;
  logic [7:0]     cnt_reg;
  logic [2:0]     idx_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           start_reg;
  logic           rb_valid_reg;
  logic [127:0]   rb_data_reg;
  logic [8:0]     imem_waddr_reg;
  logic [31:0]    instr_write_reg;
  logic           instr_we_reg;
  logic [7:0]     dmem_waddr_reg;
  logic [63:0]    dmem_wdata_reg;
  logic           dmem_we_reg;
  logic           cmd_accept;

  // go wins over a same-cycle command; reset forces ready low as well.
  assign cmd_ready  = (state_reg == S_IDLE) && !go && !reset;
  assign cmd_accept = cmd_valid && cmd_ready;

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign start             = start_reg;
  assign rb_valid          = rb_valid_reg;
  assign rb_data           = rb_data_reg;
  assign rb_index          = idx_reg;
  assign regfile_raddr_ver = idx_reg;
  assign mem_raddr_ver     = {5'd0, idx_reg};
  assign imem_waddr_pre    = imem_waddr_reg;
  assign instr_write_pre   = instr_write_reg;
  assign instr_we_pre      = instr_we_reg;
  assign dmem_waddr_pre    = dmem_waddr_reg;
  assign dmem_wdata_pre    = dmem_wdata_reg;
  assign dmem_we_pre       = dmem_we_reg;

  // Sequencer FSM with registered preload port, run control and readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= 8'd0;
      idx_reg         <= 3'd0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      start_reg       <= 1'b0;
      rb_valid_reg    <= 1'b0;
      rb_data_reg     <= '0;
      imem_waddr_reg  <= 9'd0;
      instr_write_reg <= 32'd0;
      instr_we_reg    <= 1'b0;
      dmem_waddr_reg  <= 8'd0;
      dmem_wdata_reg  <= 64'd0;
      dmem_we_reg     <= 1'b0;
    end else begin
      // write enables and done are single-cycle pulses
      instr_we_reg <= 1'b0;
      dmem_we_reg  <= 1'b0;
      done_reg     <= 1'b0;

      if (cmd_accept) begin
        if (cmd_type) begin
          dmem_we_reg    <= 1'b1;
          dmem_waddr_reg <= cmd_addr[7:0];
          dmem_wdata_reg <= cmd_data;
        end else begin
          instr_we_reg    <= 1'b1;
          imem_waddr_reg  <= cmd_addr;
          instr_write_reg <= cmd_data[31:0];
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (go) begin
            state_reg <= S_RUN;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            cnt_reg   <= RUN_LOAD;
          end
        end
        S_RUN: begin
          if (cnt_reg == 8'd0) begin
            start_reg <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              state_reg <= S_RADDR;
            end else begin
              state_reg <= S_DRAIN;
              cnt_reg   <= DRAIN_LOAD;
            end
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        S_DRAIN: begin
          if (cnt_reg == 8'd0) begin
            state_reg <= S_RADDR;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        S_RADDR: begin
          // addresses have been stable a full cycle: sample both read ports
          rb_data_reg  <= {mem_rdata_ver, regfile_rdata_ver};
          rb_valid_reg <= 1'b1;
          state_reg    <= S_RVALID;
        end
        S_RVALID: begin
          if (rb_ready) begin
            rb_valid_reg <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              idx_reg   <= idx_reg + 3'd1;
              state_reg <= S_RADDR;
            end
          end
        end
        S_DONE: begin
          idx_reg   <= 3'd0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_loader.sv
// tb_pipeline_loader: directed checks of preload, run timing, readback,
// stall, go/command priority, asynchronous reset and a zero-drain variant.
module tb_pipeline_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int vec_cnt = 0;
  int err_cnt = 0;

  // default-parameter instance
  logic         cmd_valid, cmd_type, go, rb_ready;
  logic [8:0]   cmd_addr;
  logic [63:0]  cmd_data;
  logic         cmd_ready, busy, done, instr_we_pre, dmem_we_pre, start, rb_valid;
  logic [8:0]   imem_waddr_pre;
  logic [31:0]  instr_write_pre;
  logic [7:0]   dmem_waddr_pre, mem_raddr_ver;
  logic [63:0]  dmem_wdata_pre, regfile_rdata_ver, mem_rdata_ver;
  logic [2:0]   regfile_raddr_ver, rb_index;
  logic [127:0] rb_data;

  // zero-drain, single-beat instance
  logic         z_cmd_valid, z_cmd_type, z_go, z_rb_ready;
  logic [8:0]   z_cmd_addr;
  logic [63:0]  z_cmd_data;
  logic         z_cmd_ready, z_busy, z_done, z_instr_we_pre, z_dmem_we_pre, z_start, z_rb_valid;
  logic [8:0]   z_imem_waddr_pre;
  logic [31:0]  z_instr_write_pre;
  logic [7:0]   z_dmem_waddr_pre, z_mem_raddr_ver;
  logic [63:0]  z_dmem_wdata_pre, z_regfile_rdata_ver, z_mem_rdata_ver;
  logic [2:0]   z_regfile_raddr_ver, z_rb_index;
  logic [127:0] z_rb_data;

  pipeline_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .go(go), .busy(busy), .done(done),
    .imem_waddr_pre(imem_waddr_pre), .instr_write_pre(instr_write_pre), .instr_we_pre(instr_we_pre),
    .dmem_waddr_pre(dmem_waddr_pre), .dmem_wdata_pre(dmem_wdata_pre), .dmem_we_pre(dmem_we_pre),
    .start(start), .regfile_raddr_ver(regfile_raddr_ver), .mem_raddr_ver(mem_raddr_ver),
    .regfile_rdata_ver(regfile_rdata_ver), .mem_rdata_ver(mem_rdata_ver),
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_index(rb_index), .rb_data(rb_data)
  );

  pipeline_loader #(.RUN_CYCLES(6), .DRAIN_CYCLES(0), .RB_COUNT(1)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_type(z_cmd_type),
    .cmd_addr(z_cmd_addr), .cmd_data(z_cmd_data),
    .go(z_go), .busy(z_busy), .done(z_done),
    .imem_waddr_pre(z_imem_waddr_pre), .instr_write_pre(z_instr_write_pre), .instr_we_pre(z_instr_we_pre),
    .dmem_waddr_pre(z_dmem_waddr_pre), .dmem_wdata_pre(z_dmem_wdata_pre), .dmem_we_pre(z_dmem_we_pre),
    .start(z_start), .regfile_raddr_ver(z_regfile_raddr_ver), .mem_raddr_ver(z_mem_raddr_ver),
    .regfile_rdata_ver(z_regfile_rdata_ver), .mem_rdata_ver(z_mem_rdata_ver),
    .rb_valid(z_rb_valid), .rb_ready(z_rb_ready), .rb_index(z_rb_index), .rb_data(z_rb_data)
  );

  // Pipeline stand-in: D-MEM filled by the preload port, regfile is a fixed pattern.
  logic [63:0] dmem_m [256];
  always @(posedge clk) begin
    if (dmem_we_pre) dmem_m[dmem_waddr_pre] <= dmem_wdata_pre;
  end
  assign mem_rdata_ver       = dmem_m[mem_raddr_ver];
  assign regfile_rdata_ver   = 64'hA000 + {61'd0, regfile_raddr_ver};
  assign z_mem_rdata_ver     = 64'hD000 + {56'd0, z_mem_raddr_ver};
  assign z_regfile_rdata_ver = 64'hA000 + {61'd0, z_regfile_raddr_ver};

  logic [31:0] imem_words [8];
  logic [63:0] dmem_words [8];

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (start !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin err_cnt++; $display("FAIL reset_ctrl: start/busy/done=%b%b%b expected 000", start, busy, done); end
    vec_cnt++; if (instr_we_pre !== 1'b0 || dmem_we_pre !== 1'b0 || rb_valid !== 1'b0)
      begin err_cnt++; $display("FAIL reset_we: iwe/dwe/rbv=%b%b%b expected 000", instr_we_pre, dmem_we_pre, rb_valid); end
    vec_cnt++; if (rb_data !== 128'd0 || regfile_raddr_ver !== 3'd0 || cmd_ready !== 1'b0)
      begin err_cnt++; $display("FAIL reset_data: rb_data=%0h raddr=%0d cmd_ready=%b expected 0 0 0", rb_data, regfile_raddr_ver, cmd_ready); end
    reset = 1'b0;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b1)
      begin err_cnt++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    $display("reset: checked idle state");
  endtask

  task automatic test_preload();
    for (int i = 0; i < 16; i++) begin
      cmd_valid = 1'b1;
      cmd_type  = (i >= 8);
      cmd_addr  = 9'(i % 8);
      cmd_data  = (i < 8) ? {32'hFFFF_FFFF, imem_words[i]} : dmem_words[i-8];
      #1;
      vec_cnt++; if (cmd_ready !== 1'b1)
        begin err_cnt++; $display("FAIL preload_ready[%0d]: got %b expected 1", i, cmd_ready); end
      @(posedge clk); #1;
      if (i < 8) begin
        vec_cnt++; if (instr_we_pre !== 1'b1 || dmem_we_pre !== 1'b0)
          begin err_cnt++; $display("FAIL imem_we[%0d]: iwe/dwe=%b%b expected 10", i, instr_we_pre, dmem_we_pre); end
        vec_cnt++; if (imem_waddr_pre !== 9'(i) || instr_write_pre !== imem_words[i])
          begin err_cnt++; $display("FAIL imem_write[%0d]: addr=%0d data=%h expected %0d %h", i, imem_waddr_pre, instr_write_pre, i, imem_words[i]); end
      end else begin
        vec_cnt++; if (dmem_we_pre !== 1'b1 || instr_we_pre !== 1'b0)
          begin err_cnt++; $display("FAIL dmem_we[%0d]: iwe/dwe=%b%b expected 01", i, instr_we_pre, dmem_we_pre); end
        vec_cnt++; if (dmem_waddr_pre !== 8'(i - 8) || dmem_wdata_pre !== dmem_words[i-8])
          begin err_cnt++; $display("FAIL dmem_write[%0d]: addr=%0d data=%h expected %0d %h", i, dmem_waddr_pre, dmem_wdata_pre, i - 8, dmem_words[i-8]); end
      end
      $display("preload %0d: type=%0d addr=%0d", i, cmd_type, cmd_addr);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (instr_we_pre !== 1'b0 || dmem_we_pre !== 1'b0)
      begin err_cnt++; $display("FAIL preload_end_we: iwe/dwe=%b%b expected 00", instr_we_pre, dmem_we_pre); end
  endtask

  // Pulses go at the next edge, then services the readback stream.
  // k counts samples taken 1 time unit after edge G+k.
  task automatic run_collect(input int stall_idx, input int stall_len, input bit with_cmd,
                             input bit second_go, output int start_w, output int first_v,
                             output int done_k, output int nbeats);
    int stalled;
    logic [127:0] held_data;
    logic [2:0] held_idx;
    logic busy_prev;
    start_w = 0; first_v = -1; done_k = -1; nbeats = 0; stalled = 0;
    held_data = '0; held_idx = '0; busy_prev = 1'b0;
    rb_ready = 1'b1;
    go = 1'b1;
    if (with_cmd) begin
      cmd_valid = 1'b1; cmd_type = 1'b1; cmd_addr = 9'd0; cmd_data = 64'hDEAD;
    end
    #1;
    vec_cnt++; if (cmd_ready !== 1'b0)
      begin err_cnt++; $display("FAIL go_blocks_cmd: cmd_ready=%b expected 0", cmd_ready); end
    @(posedge clk); #1;
    go = 1'b0; cmd_valid = 1'b0;
    if (with_cmd) begin
      vec_cnt++; if (instr_we_pre !== 1'b0 || dmem_we_pre !== 1'b0)
        begin err_cnt++; $display("FAIL go_cmd_no_write: iwe/dwe=%b%b expected 00", instr_we_pre, dmem_we_pre); end
    end
    for (int k = 0; k < 200; k++) begin
      if (k == 0) begin
        vec_cnt++; if (busy !== 1'b1 || start !== 1'b1)
          begin err_cnt++; $display("FAIL run_entry: busy/start=%b%b expected 11", busy, start); end
      end
      if (k == 1) begin
        vec_cnt++; if (cmd_ready !== 1'b0)
          begin err_cnt++; $display("FAIL run_cmd_ready: got %b expected 0", cmd_ready); end
      end
      if (second_go) go = (k == 2);
      if (start) start_w++;
      if (rb_valid && first_v < 0) first_v = k;
      if (done) begin
        done_k = k;
        vec_cnt++; if (busy !== 1'b0 || busy_prev !== 1'b1)
          begin err_cnt++; $display("FAIL busy_at_done: busy=%b prev=%b expected 0 1", busy, busy_prev); end
        break;
      end
      busy_prev = busy;
      if (rb_valid) begin
        if (int'(rb_index) == stall_idx && stalled < stall_len) begin
          if (stalled == 0) begin
            held_data = rb_data; held_idx = rb_index;
          end else begin
            vec_cnt++; if (rb_data !== held_data || rb_index !== held_idx || regfile_raddr_ver !== held_idx || mem_raddr_ver !== {5'd0, held_idx})
              begin err_cnt++; $display("FAIL stall_hold: idx=%0d data=%h raddr=%0d expected %0d %h", rb_index, rb_data, regfile_raddr_ver, held_idx, held_data); end
          end
          stalled++;
          rb_ready = 1'b0;
        end else begin
          rb_ready = 1'b1;
          vec_cnt++; if (int'(rb_index) != nbeats)
            begin err_cnt++; $display("FAIL beat_index: got %0d expected %0d", rb_index, nbeats); end
          if (nbeats < 8) begin
            vec_cnt++; if (rb_data[127:64] !== dmem_words[nbeats] || rb_data[63:0] !== 64'hA000 + 64'(nbeats))
              begin err_cnt++; $display("FAIL beat_data[%0d]: got %h expected %h_%h", nbeats, rb_data, dmem_words[nbeats], 64'hA000 + 64'(nbeats)); end
          end
          $display("beat %0d: index=%0d data=%h", nbeats, rb_index, rb_data);
          nbeats++;
        end
      end
      @(posedge clk); #1;
    end
    go = 1'b0; rb_ready = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (done !== 1'b0 || busy !== 1'b0)
      begin err_cnt++; $display("FAIL done_pulse_width: done/busy=%b%b expected 00", done, busy); end
  endtask

  task automatic check_run(input string name, input int start_w, input int first_v,
                           input int done_k, input int nbeats, input int exp_done);
    vec_cnt++; if (start_w != 6)
      begin err_cnt++; $display("FAIL %s start_width: got %0d expected 6", name, start_w); end
    vec_cnt++; if (first_v != 12)
      begin err_cnt++; $display("FAIL %s first_valid: got %0d expected 12", name, first_v); end
    vec_cnt++; if (done_k != exp_done)
      begin err_cnt++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_k, exp_done); end
    vec_cnt++; if (nbeats != 6)
      begin err_cnt++; $display("FAIL %s beat_count: got %0d expected 6", name, nbeats); end
    $display("%s: start=%0d first_valid=%0d done=%0d beats=%0d", name, start_w, first_v, done_k, nbeats);
  endtask

  task automatic test_run_default();
    int sw, fv, dk, nb;
    run_collect(-1, 0, 1'b0, 1'b0, sw, fv, dk, nb);
    check_run("run_default", sw, fv, dk, nb, 23);
  endtask

  task automatic test_stall();
    int sw, fv, dk, nb;
    run_collect(2, 5, 1'b0, 1'b0, sw, fv, dk, nb);
    check_run("stall", sw, fv, dk, nb, 28);
  endtask

  task automatic test_go_with_cmd();
    int sw, fv, dk, nb;
    run_collect(-1, 0, 1'b1, 1'b1, sw, fv, dk, nb);
    check_run("go_with_cmd", sw, fv, dk, nb, 23);
  endtask

  task automatic test_reset_mid_run();
    int sw, fv, dk, nb;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vec_cnt++; if (start !== 1'b1)
      begin err_cnt++; $display("FAIL mid_run_start: got %b expected 1", start); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (start !== 1'b0 || busy !== 1'b0)
      begin err_cnt++; $display("FAIL async_reset: start/busy=%b%b expected 00", start, busy); end
    vec_cnt++; if (rb_data !== 128'd0 || rb_valid !== 1'b0)
      begin err_cnt++; $display("FAIL async_reset_rb: rb_data=%h rb_valid=%b expected 0 0", rb_data, rb_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vec_cnt++; if (cmd_ready !== 1'b1 || start !== 1'b0)
      begin err_cnt++; $display("FAIL post_reset: cmd_ready/start=%b%b expected 10", cmd_ready, start); end
    $display("reset mid-run: released");
    run_collect(-1, 0, 1'b0, 1'b0, sw, fv, dk, nb);
    check_run("after_reset", sw, fv, dk, nb, 23);
  endtask

  task automatic test_drain0();
    bit s_hist [12];
    bit v_hist [12];
    bit d_hist [12];
    bit b_hist [12];
    logic [127:0] data7;
    logic [2:0] idx7;
    int s_cnt, v_cnt, d_cnt;
    data7 = '0; idx7 = 3'd7;
    z_go = 1'b1;
    @(posedge clk); #1;
    z_go = 1'b0;
    z_rb_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      s_hist[k] = z_start; v_hist[k] = z_rb_valid; d_hist[k] = z_done; b_hist[k] = z_busy;
      if (k == 7) begin data7 = z_rb_data; idx7 = z_rb_index; end
      @(posedge clk); #1;
    end
    s_cnt = 0; v_cnt = 0; d_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      s_cnt += int'(s_hist[k]); v_cnt += int'(v_hist[k]); d_cnt += int'(d_hist[k]);
    end
    vec_cnt++; if (s_cnt != 6 || s_hist[5] !== 1'b1 || s_hist[6] !== 1'b0)
      begin err_cnt++; $display("FAIL drain0_start: width=%0d s5=%b s6=%b expected 6 1 0", s_cnt, s_hist[5], s_hist[6]); end
    vec_cnt++; if (v_hist[6] !== 1'b0 || v_hist[7] !== 1'b1 || v_cnt != 1)
      begin err_cnt++; $display("FAIL drain0_valid: v6=%b v7=%b count=%0d expected 0 1 1", v_hist[6], v_hist[7], v_cnt); end
    vec_cnt++; if (idx7 !== 3'd0 || data7 !== {64'hD000, 64'hA000})
      begin err_cnt++; $display("FAIL drain0_beat: idx=%0d data=%h expected 0 %h", idx7, data7, {64'hD000, 64'hA000}); end
    vec_cnt++; if (d_hist[8] !== 1'b1 || d_cnt != 1 || b_hist[8] !== 1'b0 || b_hist[7] !== 1'b1)
      begin err_cnt++; $display("FAIL drain0_done: d8=%b count=%0d busy7/8=%b%b expected 1 1 10", d_hist[8], d_cnt, b_hist[7], b_hist[8]); end
    $display("drain0: start=%0d valid_beats=%0d done_pulses=%0d", s_cnt, v_cnt, d_cnt);
  endtask

  initial begin
    // program: LD R2,R0; LD R3,R0; NOOP x3; ST R2,R1; NOOP x2 (payload words)
    imem_words = '{32'h0C40_0000, 32'h0C60_0000, 32'h0000_0000, 32'h0000_0000,
                   32'h0000_0000, 32'h1C41_0000, 32'h0000_0000, 32'h0000_0000};
    dmem_words = '{64'd4, 64'd2, 64'd3, 64'd4, 64'h64, 64'd6, 64'd7, 64'd8};
    cmd_valid = 1'b0; cmd_type = 1'b0; cmd_addr = '0; cmd_data = '0; go = 1'b0; rb_ready = 1'b0;
    z_cmd_valid = 1'b0; z_cmd_type = 1'b0; z_cmd_addr = '0; z_cmd_data = '0; z_go = 1'b0; z_rb_ready = 1'b0;
    test_reset();
    test_preload();
    test_run_default();
    test_stall();
    test_go_with_cmd();
    test_reset_mid_run();
    test_drain0();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
